// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// bcd_stopwatch_ctrl_pkg: shared state encoding and BCD constants
package bcd_stopwatch_ctrl_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_e;
    localparam logic [3:0] DIGIT_MAX = 4'd9;
endpackage

// File: rtl/bcd_stopwatch_ctrl_if.sv
// bcd_stopwatch_ctrl_if: command inputs and count/status outputs of the stopwatch
interface bcd_stopwatch_ctrl_if #(parameter int NDIGITS = 4);
    logic                   start;
    logic                   stop;
    logic                   clear;
    logic                   lap;
    logic [4*NDIGITS-1:0]   digits;
    logic [4*NDIGITS-1:0]   lap_digits;
    logic                   lap_valid;
    logic                   running;
    logic                   overflow;
    logic [1:0]             state;
    modport master (output start, stop, clear, lap,
                    input digits, lap_digits, lap_valid, running, overflow, state);
    modport slave  (input start, stop, clear, lap,
                    output digits, lap_digits, lap_valid, running, overflow, state);
endinterface

// File: rtl/bcd_stopwatch_ctrl_digit.sv
// bcd_digit: one mod-10 counter stage with clear and ripple carry
module bcd_digit
    import bcd_stopwatch_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);
    logic [3:0] q_d, q_q;
    // next digit: clear wins, otherwise count 0..9 when enabled
    always_comb q_d = clr ? 4'd0 : !inc ? q_q : (q_q == DIGIT_MAX) ? 4'd0 : q_q + 4'd1;
    // digit register
    always_ff @(posedge clk or posedge rst)
        if (rst) q_q <= 4'd0;
        else     q_q <= q_d;
    assign q     = q_q;
    assign carry = inc && (q_q == DIGIT_MAX);
endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl: start/stop/lap/clear stopwatch over a BCD digit chain
module bcd_stopwatch_ctrl
    import bcd_stopwatch_ctrl_pkg::*;
#(
    parameter int NDIGITS  = 4,
    parameter int TICK_DIV = 10
) (
    input logic                    clk,
    input logic                    rst,
    bcd_stopwatch_ctrl_if.slave    bus
);
    localparam int            PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    state_e                       state_q;
    logic                         running_q;
    logic [PW-1:0]                psc_d, psc_q;
    logic [4*NDIGITS-1:0]         lap_d, lap_q;
    logic                         lap_valid_d, lap_valid_q;
    logic                         ovf_d, ovf_q;
    logic                         tick, lap_take;
    logic [NDIGITS-1:0]           inc, cy;
    logic [NDIGITS-1:0][3:0]      dq;
    logic [4*NDIGITS-1:0]         cnt;

    assign cnt = dq;

    for (genvar g = 0; g < NDIGITS; g++) begin : g_dig
        if (g == 0) begin : g_first
            assign inc[g] = tick;
        end else begin : g_rest
            assign inc[g] = cy[g-1];
        end
        bcd_digit u_dig (.clk(clk), .rst(rst), .clr(bus.clear), .inc(inc[g]), .q(dq[g]), .carry(cy[g]));
    end

    // prescaler, lap snapshot and sticky overflow next-state; clear dominates
    always_comb begin
        tick        = (state_q == RUN) && (psc_q == PMAX);
        psc_d       = bus.clear ? '0 : (state_q != RUN) ? psc_q : tick ? '0 : psc_q + PW'(1);
        lap_take    = bus.lap && !bus.clear && (state_q != IDLE);
        lap_d       = bus.clear ? '0 : lap_take ? cnt : lap_q;
        lap_valid_d = !bus.clear && (lap_valid_q || lap_take);
        ovf_d       = !bus.clear && (ovf_q || cy[NDIGITS-1]);
    end

    // command FSM: clear > stop > start, running registered alongside state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
        end else if (bus.clear) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
        end else if (bus.stop) begin
            if (state_q == RUN) begin
                state_q   <= PAUSE;
                running_q <= 1'b0;
            end
        end else if (bus.start && state_q != RUN) begin
            state_q   <= RUN;
            running_q <= 1'b1;
        end
    end

    // datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_q       <= '0;
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            psc_q       <= psc_d;
            lap_q       <= lap_d;
            lap_valid_q <= lap_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.digits     = cnt;
    assign bus.lap_digits = lap_q;
    assign bus.lap_valid  = lap_valid_q;
    assign bus.running    = running_q;
    assign bus.overflow   = ovf_q;
    assign bus.state      = state_q;
endmodule
